// File: rtl/cam_window_capture.sv
// Camera capture stage: samples the 8-bit camera bus, assembles RGB565 pixels,
// crops a window and emits sequential frame-buffer writes (RGB565 or grayscale).
module cam_window_capture #(
    parameter int MAX_W     = 640,
    parameter int MAX_H     = 480,
    parameter int WIN_X0    = 0,
    parameter int WIN_Y0    = 0,
    parameter int WIN_W     = 150,
    parameter int WIN_H     = 150,
    parameter int ADDR_W    = 15,
    parameter int BYTE_SWAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cam_vsync,
    input  logic              i_cam_href,
    input  logic [7:0]        i_cam_data,
    input  logic              i_gray_mode,
    input  logic              i_freeze,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_frame_done,
    output logic              o_capturing,
    output logic [7:0]        o_frame_cnt,
    output logic              o_line_err
);

    localparam int XW = $clog2(MAX_W + 1);
    localparam int YW = $clog2(MAX_H + 1);
    localparam logic [XW-1:0] X_MAX = XW'(MAX_W);
    localparam logic [YW-1:0] Y_MAX = YW'(MAX_H);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Luma with each channel widened to 8 bits by bit replication; the sum peaks at 65280.
    function automatic logic [7:0] f_gray(input logic [15:0] pix);
        logic [15:0] r8;
        logic [15:0] g8;
        logic [15:0] b8;
        logic [15:0] sum;
        r8  = {8'd0, pix[15:11], pix[15:13]};
        g8  = {8'd0, pix[10:5], pix[10:9]};
        b8  = {8'd0, pix[4:0], pix[4:2]};
        sum = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;
        return sum[15:8];
    endfunction

    logic              r_vs;
    logic              r_vs_d;
    logic              r_href;
    logic              r_href_d;
    logic [7:0]        r_data;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_gray;
    logic [7:0]        r_first;
    logic              r_phase;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_addr;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_frame_done;
    logic              r_capturing;
    logic [7:0]        r_frame_cnt;
    logic              r_line_err;

    logic              w_vs_rise;
    logic              w_vs_fall;
    logic              w_href_fall;
    logic              w_pix_done;
    logic [15:0]       w_pixel;
    logic signed [31:0] w_xi;
    logic signed [31:0] w_yi;
    logic              w_in_win;
    logic              w_write;
    logic              w_frame_end;
    logic              w_line_bad;

    assign w_vs_rise   = r_vs & ~r_vs_d;
    assign w_vs_fall   = ~r_vs & r_vs_d;
    assign w_href_fall = ~r_href & r_href_d;
    assign w_pix_done  = r_href & r_phase;
    assign w_pixel     = (BYTE_SWAP != 0) ? {r_data, r_first} : {r_first, r_data};
    assign w_xi        = 32'(r_x);
    assign w_yi        = 32'(r_y);
    assign w_in_win    = (w_xi < MAX_W) && (w_yi < MAX_H) &&
                         (w_xi >= WIN_X0) && (w_xi < WIN_X0 + WIN_W) &&
                         (w_yi >= WIN_Y0) && (w_yi < WIN_Y0 + WIN_H);
    assign w_write     = w_pix_done & w_in_win & (r_state == ST_CAPTURE);
    assign w_frame_end = w_vs_rise & (r_state == ST_CAPTURE);
    assign w_line_bad  = (w_pix_done & (r_x == X_MAX)) | (w_href_fall & r_phase);

    // Input register stage plus one-cycle delayed copies for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs     <= 1'b0;
            r_vs_d   <= 1'b0;
            r_href   <= 1'b0;
            r_href_d <= 1'b0;
            r_data   <= 8'd0;
        end else begin
            r_vs     <= i_cam_vsync;
            r_vs_d   <= r_vs;
            r_href   <= i_cam_href;
            r_href_d <= r_href;
            r_data   <= i_cam_data;
        end
    end

    // Frame state sequencing; SYNC discards whatever partial frame follows reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC: begin
                if (w_vs_rise) w_state_nxt = ST_WAIT;
                else           w_state_nxt = ST_SYNC;
            end
            ST_WAIT: begin
                if (w_vs_fall) w_state_nxt = i_freeze ? ST_HOLD : ST_CAPTURE;
                else           w_state_nxt = ST_WAIT;
            end
            ST_CAPTURE: begin
                if (w_vs_rise) w_state_nxt = ST_WAIT;
                else           w_state_nxt = ST_CAPTURE;
            end
            ST_HOLD: begin
                if (w_vs_rise) w_state_nxt = ST_WAIT;
                else           w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    // Raster position, byte phase and window address tracking (runs in every state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
            r_gray  <= 1'b0;
            r_first <= 8'd0;
            r_phase <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_vs_fall) begin
                r_gray  <= i_gray_mode;
                r_phase <= 1'b0;
                r_x     <= '0;
                r_y     <= '0;
                r_addr  <= '0;
            end else if (r_href) begin
                if (!r_phase) begin
                    r_first <= r_data;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    r_x     <= (r_x == X_MAX) ? X_MAX : r_x + XW'(1);
                    if (w_write) r_addr <= r_addr + ADDR_W'(1);
                end
            end else if (w_href_fall) begin
                r_phase <= 1'b0;
                r_x     <= '0;
                r_y     <= (r_y == Y_MAX) ? Y_MAX : r_y + YW'(1);
            end
        end
    end

    // Registered write port, frame status and sticky line error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 16'd0;
            r_frame_done <= 1'b0;
            r_capturing  <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_line_err   <= 1'b0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= r_addr;
                r_wr_data <= r_gray ? {8'd0, f_gray(w_pixel)} : w_pixel;
            end
            r_frame_done <= w_frame_end;
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
            r_capturing <= (w_state_nxt == ST_CAPTURE);
            if (w_line_bad) r_line_err <= 1'b1;
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_frame_done = r_frame_done;
    assign o_capturing  = r_capturing;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_line_err   = r_line_err;

endmodule

// File: tb/tb_cam_window_capture.sv
// Directed + randomized bench for cam_window_capture against a frame-level reference model.
module tb_cam_window_capture;

    localparam int MAX_W = 8, MAX_H = 6, WIN_X0 = 2, WIN_Y0 = 1, WIN_W = 3, WIN_H = 2;
    localparam int ADDR_W = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0] cam_data = 8'd0;
    logic gray_mode = 1'b0, freeze = 1'b0;
    logic o_wr_en, o_frame_done, o_capturing, o_line_err;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic [7:0] o_frame_cnt;

    cam_window_capture #(
        .MAX_W(MAX_W), .MAX_H(MAX_H), .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
        .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W), .BYTE_SWAP(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cam_vsync(cam_vsync), .i_cam_href(cam_href), .i_cam_data(cam_data),
        .i_gray_mode(gray_mode), .i_freeze(freeze),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_frame_done(o_frame_done), .o_capturing(o_capturing),
        .o_frame_cnt(o_frame_cnt), .o_line_err(o_line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    // Observed traffic
    logic [ADDR_W-1:0] act_addr[$];
    logic [15:0] act_data[$];
    int first_wr_cyc = 0, done_cnt = 0, done_cyc = 0, b2b = 0, done_before = 0;
    logic [7:0] done_fc = 8'd0;
    logic prev_wr = 1'b0;

    // Reference model state
    logic [15:0] pix [8][16];
    int nb [8];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [15:0] const_q[$];
    logic [7:0] exp_cnt = 8'd0;
    logic exp_err = 1'b0;
    int vs_cyc = 0, first_drive = -1;

    always @(negedge clk) begin
        if (o_wr_en) begin
            if (act_addr.size() == 0) first_wr_cyc = cyc;
            act_addr.push_back(o_wr_addr);
            act_data.push_back(o_wr_data);
        end
        if (o_wr_en && prev_wr) b2b++;
        prev_wr = o_wr_en;
        if (o_frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_fc = o_frame_cnt;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] p);
        int r, g, b, r8, g8, b8;
        r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
    endfunction

    function automatic bit in_win(input int x, input int y);
        return (x >= WIN_X0) && (x < WIN_X0 + WIN_W) && (y >= WIN_Y0) && (y < WIN_Y0 + WIN_H)
               && (x < MAX_W) && (y < MAX_H);
    endfunction

    task automatic fill_xy();
        for (int y = 0; y < 8; y++) begin
            nb[y] = 2 * MAX_W;
            for (int x = 0; x < 16; x++) pix[y][x] = 16'((y << 8) | (x << 4));
        end
    endtask

    task automatic fill_rand();
        for (int y = 0; y < 8; y++) begin
            nb[y] = 2 * MAX_W;
            for (int x = 0; x < 16; x++) pix[y][x] = 16'($urandom);
        end
    endtask

    task automatic model_frame(input int nlines, input bit gm, input bit cap);
        int a = 0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < nb[y] / 2; x++) begin
                if (x >= MAX_W) exp_err = 1'b1;
                else if (cap && in_win(x, y)) begin
                    exp_addr.push_back(ADDR_W'(a));
                    exp_data.push_back(gm ? {8'd0, ref_gray(pix[y][x])} : pix[y][x]);
                    a++;
                end
            end
            if (nb[y] % 2 == 1) exp_err = 1'b1;
        end
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        cam_vsync = 1'b1;
        vs_cyc = cyc;
        repeat (4) @(negedge clk);
    endtask

    task automatic body(input int nlines, input bit gm, input bit fz, input bit cap, input int rst_line);
        logic [15:0] px;
        cam_vsync = 1'b0;
        gray_mode = gm;
        freeze = fz;
        first_drive = -1;
        repeat (3) @(negedge clk);
        chk("capturing_in_frame", {31'd0, o_capturing}, {31'd0, cap});
        for (int y = 0; y < nlines; y++) begin
            if (y == rst_line) begin
                rst_n = 1'b0;
                #1;
                chk("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
                chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
                chk("rst_wr_data", {16'd0, o_wr_data}, 32'd0);
                chk("rst_capturing", {31'd0, o_capturing}, 32'd0);
                chk("rst_frame_cnt", {24'd0, o_frame_cnt}, 32'd0);
                chk("rst_line_err", {31'd0, o_line_err}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
            end
            if (y == 1) begin
                gray_mode = ~gm;
                freeze = ~fz;
            end
            for (int i = 0; i < nb[y]; i++) begin
                cam_href = 1'b1;
                px = pix[y][i / 2];
                cam_data = (i % 2 == 0) ? px[15:8] : px[7:0];
                if (i % 2 == 1 && first_drive < 0 && in_win(i / 2, y)) first_drive = cyc;
                @(negedge clk);
            end
            cam_href = 1'b0;
            cam_data = 8'd0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic check_frame(input bit exp_done);
        int n;
        chk("num_writes", act_addr.size(), exp_addr.size());
        n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", 32'(act_addr[i]), 32'(exp_addr[i]));
            chk("wr_data", {16'd0, act_data[i]}, {16'd0, exp_data[i]});
        end
        for (int i = 0; i < const_q.size() && i < act_data.size(); i++)
            chk("wr_data_const", {16'd0, act_data[i]}, {16'd0, const_q[i]});
        if (exp_addr.size() > 0 && first_drive >= 0)
            chk("wr_latency", first_wr_cyc - first_drive, 32'd2);
        chk("done_pulses", done_cnt - done_before, {31'd0, exp_done});
        if (exp_done) begin
            chk("done_latency", done_cyc - vs_cyc, 32'd2);
            chk("cnt_at_done", {24'd0, done_fc}, {24'd0, exp_cnt});
        end
        chk("frame_cnt", {24'd0, o_frame_cnt}, {24'd0, exp_cnt});
        chk("line_err", {31'd0, o_line_err}, {31'd0, exp_err});
        chk("capturing_idle", {31'd0, o_capturing}, 32'd0);
        act_addr.delete(); act_data.delete();
        exp_addr.delete(); exp_data.delete(); const_q.delete();
        done_before = done_cnt;
    endtask

    task automatic do_frame(input int nlines, input bit gm, input bit fz, input int rst_line);
        bit cap;
        cap = !fz;
        model_frame((rst_line >= 0) ? rst_line : nlines, gm, cap);
        body(nlines, gm, fz, cap, rst_line);
        if (rst_line >= 0) begin
            exp_err = 1'b0;
            exp_cnt = 8'd0;
        end else if (cap) begin
            exp_cnt = exp_cnt + 8'd1;
        end
        vs_pulse();
        check_frame(cap && rst_line < 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("reset_frame_done", {31'd0, o_frame_done}, 32'd0);
        chk("reset_frame_cnt", {24'd0, o_frame_cnt}, 32'd0);
        chk("reset_line_err", {31'd0, o_line_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A frame before the first vsync rise must be ignored
        fill_xy();
        model_frame(0, 1'b0, 1'b0);
        body(3, 1'b0, 1'b0, 1'b0, -1);
        vs_pulse();
        check_frame(1'b0);

        // RGB {y,x} pattern
        fill_xy();
        const_q = '{16'h0120, 16'h0130, 16'h0140, 16'h0220, 16'h0230, 16'h0240};
        do_frame(6, 1'b0, 1'b0, -1);

        // Grayscale known values
        fill_xy();
        pix[1][2] = 16'hF800; pix[1][3] = 16'h07E0; pix[1][4] = 16'h001F;
        pix[2][2] = 16'hFFFF; pix[2][3] = 16'h0000; pix[2][4] = 16'h0000;
        const_q = '{16'd76, 16'd149, 16'd28, 16'd255, 16'd0, 16'd0};
        do_frame(6, 1'b1, 1'b0, -1);

        // Freeze, then a normal frame
        fill_xy();
        do_frame(6, 1'b0, 1'b1, -1);
        do_frame(6, 1'b0, 1'b0, -1);

        // Randomized frames, including more lines than MAX_H
        for (int f = 0; f < 6; f++) begin
            fill_rand();
            do_frame(int'($urandom_range(3, 7)), 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        // Odd-length line and over-long line
        fill_rand();
        nb[1] = 5;
        nb[3] = 2 * (MAX_W + 1);
        do_frame(6, 1'b0, 1'b0, -1);
        fill_rand();
        do_frame(6, 1'b1, 1'b0, -1);

        // Reset mid-frame, then a full frame
        fill_xy();
        do_frame(6, 1'b0, 1'b0, 2);
        do_frame(6, 1'b0, 1'b0, -1);

        // Frame counter wrap
        for (int f = 0; f < 255; f++) begin
            fill_xy();
            do_frame(3, 1'b0, 1'b0, -1);
        end
        chk("frame_cnt_wrap", {24'd0, o_frame_cnt}, 32'd0);
        do_frame(3, 1'b0, 1'b0, -1);
        chk("frame_cnt_after_wrap", {24'd0, o_frame_cnt}, 32'd1);

        chk("no_back_to_back_writes", b2b, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_window_capture.md
# cam_window_capture

Parametrised camera-side capture stage for the edge-detection pipeline. It samples the 8-bit camera bus in the camera pixel-clock domain and assembles byte pairs into RGB565 pixels. It crops a configurable rectangular window out of the raster and emits frame-buffer write strobes for that window only, with sequential addresses. It supports RGB565 pass-through or 8-bit grayscale, frame-granular freeze, a frame counter and a malformed-line flag, and sits between the camera pins and the frame buffer's write port.

## Interface
- MAX_W, 640: pixels per line; pixels beyond this are dropped.
- MAX_H, 480: lines per frame; lines beyond this are dropped.
- WIN_X0, 0: first captured column.
- WIN_Y0, 0: first captured line.
- WIN_W, 150: window width in pixels.
- WIN_H, 150: window height in lines.
- ADDR_W, 15: write-address width; must satisfy 2^ADDR_W >= WIN_W*WIN_H.
- BYTE_SWAP, 0: 0 = first byte of a pair is the pixel's high byte; 1 = the first byte is the low byte.
- clk  in  1  camera pixel clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cam_vsync  in  1  high during vertical blanking.
- cam_href  in  1  high while line bytes are valid.
- cam_data  in  8  camera data byte.
- gray_mode  in  1  1 = write grayscale, 0 = write RGB565; latched at frame start.
- freeze  in  1  1 = skip the next frame (no writes); latched at frame start.
- wr_en  out  1  write strobe, one cycle per window pixel.
- wr_addr  out  ADDR_W  linear window address.
- wr_data  out  16  RGB565 pixel, or {8'd0, gray}.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- capturing  out  1  high while in state CAPTURE.
- frame_cnt  out  8  count of captured frames; wraps from 255 to 0.
- line_err  out  1  sticky flag: odd byte count on a line, or line longer than MAX_W; cleared only by reset.

## Operation
- cam_vsync, cam_href and cam_data pass through one input register stage. All edge detection uses the registered signals.
- State machine:
  - SYNC (reset state) -> WAIT on a vsync rising edge. This discards any partial frame seen after reset.
  - WAIT -> CAPTURE on a vsync falling edge if freeze=0.
  - WAIT -> HOLD on a vsync falling edge if freeze=1.
  - CAPTURE -> WAIT on a vsync rising edge. frame_done pulses and frame_cnt increments.
  - HOLD -> WAIT on a vsync rising edge. No frame_done pulse.
- At every vsync falling edge: x=0, y=0, byte phase=0, wr_addr counter=0. gray_mode and freeze are latched here; changes during a frame have no effect until the next frame.
- Byte assembly:
  - A byte is taken on every cycle with href high.
  - The phase toggles on each byte; phase 1 completes a pixel.
  - With BYTE_SWAP=0 the pixel is {first, second}, i.e. R=[15:11], G=[10:5], B=[4:0].
- Per completed pixel:
  - The pixel is written if x < MAX_W, y < MAX_H, WIN_X0 <= x < WIN_X0+WIN_W and WIN_Y0 <= y < WIN_Y0+WIN_H.
  - x then increments, saturating at MAX_W.
  - A pixel completing at x = MAX_W sets line_err and is dropped.
- On the href falling edge: if phase=1, set line_err. Then phase=0, x=0, and y increments, saturating at MAX_H.
- The address counter increments after each write. The window is raster-ordered, so addresses run 0..WIN_W*WIN_H-1. No multiplier is used.
- Grayscale conversion:
  - Expand each channel to 8 bits: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
  - gray = (77*R8 + 150*G8 + 29*B8) >> 8, computed on an unsigned 16-bit sum that cannot overflow.
- Writes occur only in CAPTURE. HOLD and SYNC still track counters but never assert wr_en.

## Timing
- Reset value of every output is 0. State is SYNC and line_err is cleared.
- Write latency: the second byte is present on cam_data at edge k. It is registered at k+1. wr_en, wr_addr and wr_data are valid for exactly one cycle after edge k+2.
- Latency is identical in both modes. Back-to-back pixels produce wr_en at most every 2nd cycle.
- frame_done is asserted one cycle after the registered vsync rising edge is detected, i.e. edge m+2 for a vsync rising at edge m.
- frame_cnt updates in the same cycle as frame_done.
- A vsync rising edge in the same cycle as a pending write: the write is still issued, and frame_done follows it.
- Asserting rst_n low mid-frame clears outputs immediately, asynchronously. Capture resumes only after a full vsync high-to-low sequence.

## Test plan
All scenarios use MAX_W=8, MAX_H=6, WIN_X0=2, WIN_Y0=1, WIN_W=3, WIN_H=2.
- Full frame, RGB mode, pixel value = {y,x} encoded as 16'h0yx0:
  - Expect 6 writes at addresses 0..5 with data 16'h0120, 16'h0130, 16'h0140, 16'h0220, 16'h0230, 16'h0240.
  - Expect frame_done=1 for one cycle and frame_cnt=1.
- gray_mode=1 with pixels F800, 07E0, 001F, FFFF, 0000:
  - Expected gray values 76, 149, 28, 255, 0.
  - Each write's wr_data equals {8'd0, gray}.
- freeze=1 at a vsync falling edge:
  - No wr_en for the whole frame and no frame_done.
  - freeze=0 before the next frame: the next frame writes 6 pixels and frame_cnt increments.
- A line with 5 bytes: line_err=1 and stays 1. The following line still writes correctly, at the correct addresses.
- rst_n pulsed low mid-frame:
  - Outputs are 0 immediately.
  - The remainder of the frame produces no writes.
  - The next full frame produces 6 writes.
- 256 captured frames: frame_cnt wraps to 0, and frame_done pulses on every frame.
